// File: rtl/reg_file_pkg.sv
// Shared defaults for the decode-stage register file and its pending-write scoreboard.
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 4;
    localparam int N_READ_DEF = 2;
    localparam int PC_REG_DEF = 15;
    localparam int PC_INC_DEF = 4;
    localparam int CNT_W_DEF  = 2;

    // Largest number of in-flight writes one register can track.
    localparam int CNT_MAX = (1 << CNT_W_DEF) - 1;

endpackage

// File: rtl/reg_file_sb_cnt.sv
// One pending-write counter: counts reservations up and writebacks down,
// and never wraps in either direction.
module reg_file_sb_cnt
    import reg_file_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             atMax
);

    assign atMax = (count == {CNT_W{1'b1}});

    // Simultaneous reserve and release cancel out; otherwise step while in range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec && !atMax) begin
            count <= count + CNT_W'(1);
        end else if (dec && !inc && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Decode-stage register file: N combinational read ports with writeback bypass,
// one write port, a PC shadow register refreshed every cycle, and a per-register
// pending-write scoreboard that drives operand busy flags and the decode stall.
module reg_file_sb
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_READ = N_READ_DEF,
    parameter int PC_REG = PC_REG_DEF,
    parameter int PC_INC = PC_INC_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DATA_W-1:0]          pc,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [N_READ-1:0]          rd_en,
    input  logic [N_READ*ADDR_W-1:0]   rd_addr,
    output logic [N_READ*DATA_W-1:0]   rd_data,
    output logic [N_READ-1:0]          rd_busy,
    input  logic                       rsv_valid,
    input  logic [ADDR_W-1:0]          rsv_addr,
    output logic                       rsv_ready,
    output logic                       stall
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_REG);

    logic [DATA_W-1:0] regs   [DEPTH];
    logic [CNT_W-1:0]  cnt    [DEPTH];
    logic [DEPTH-1:0]  atMax;
    logic [DEPTH-1:0]  incVec;
    logic [DEPTH-1:0]  decVec;
    logic [DATA_W-1:0] pcNext;
    logic              rsvGrant;

    assign pcNext = pc + DATA_W'(PC_INC);

    // A full register can still be reserved when the same cycle retires one of
    // its producers; every write to a full register is a tracked release.
    assign rsv_ready = !atMax[rsv_addr] || (we && (waddr == rsv_addr));
    assign rsvGrant  = rsv_valid && rsv_ready;

    // Storage: PC shadow refreshes every cycle, a writeback to it takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            regs[PC_ADDR] <= pcNext;
            if (we) begin
                regs[waddr] <= wdata;
            end
        end
    end

    for (genvar r = 0; r < DEPTH; r++) begin : gCnt
        // Writes to a register with nothing pending are untracked and leave it at zero.
        assign incVec[r] = rsvGrant && (rsv_addr == ADDR_W'(r));
        assign decVec[r] = we && (waddr == ADDR_W'(r)) && (cnt[r] != '0);

        reg_file_sb_cnt #(
            .CNT_W (CNT_W)
        ) uCnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (incVec[r]),
            .dec   (decVec[r]),
            .count (cnt[r]),
            .atMax (atMax[r])
        );
    end

    for (genvar g = 0; g < N_READ; g++) begin : gRead
        logic [ADDR_W-1:0] addr;
        logic              hit;

        assign addr = rd_addr[g*ADDR_W +: ADDR_W];
        assign hit  = we && (waddr == addr);

        assign rd_data[g*DATA_W +: DATA_W] = hit ? wdata : regs[addr];
        // The last outstanding producer writing back this cycle is forwarded, so not busy.
        assign rd_busy[g] = (cnt[addr] != '0) && !(hit && (cnt[addr] == CNT_W'(1)));
    end

    assign stall = (|(rd_en & rd_busy)) | (rsv_valid & !rsv_ready);

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios followed by random
// traffic, all compared against a behavioural register/scoreboard model.
module tb_reg_file_sb;

    localparam int DW  = 32;
    localparam int AW  = 4;
    localparam int NR  = 2;
    localparam int MAXC = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [DW-1:0]  pc;
    logic           we;
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  wdata;
    logic [NR-1:0]  rd_en;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]  rd_busy;
    logic           rsv_valid;
    logic [AW-1:0]  rsv_addr;
    logic           rsv_ready;
    logic           stall;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mReg [16];
    int            mCnt [16];

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pc        (pc),
        .we        (we),
        .waddr     (waddr),
        .wdata     (wdata),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .stall     (stall)
    );

    task automatic checkVal(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] expRead(input logic [AW-1:0] a);
        if (we && waddr == a) return wdata;
        return mReg[a];
    endfunction

    function automatic logic expBusy(input logic [AW-1:0] a);
        if (mCnt[a] == 0) return 1'b0;
        if (we && waddr == a && mCnt[a] == 1) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic expReady();
        if (mCnt[rsv_addr] < MAXC) return 1'b1;
        return we && (waddr == rsv_addr);
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 16; i++) begin
            mReg[i] = '0;
            mCnt[i] = 0;
        end
    endtask

    task automatic idleInputs();
        we = 1'b0; waddr = '0; wdata = '0;
        rd_en = '0; rd_addr = '0;
        rsv_valid = 1'b0; rsv_addr = '0;
    endtask

    // Let combinational outputs settle, then compare every output with the model.
    task automatic settle();
        logic expStall;
        logic [AW-1:0] a;
        #1;
        expStall = rsv_valid && !expReady();
        for (int i = 0; i < NR; i++) begin
            a = rd_addr[i*AW +: AW];
            checkVal($sformatf("rdData%0d", i), rd_data[i*DW +: DW], expRead(a));
            checkVal($sformatf("rdBusy%0d", i), DW'(rd_busy[i]), DW'(expBusy(a)));
            if (rd_en[i] && expBusy(a)) expStall = 1'b1;
        end
        checkVal("rsvReady", DW'(rsv_ready), DW'(expReady()));
        checkVal("stall", DW'(stall), DW'(expStall));
    endtask

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        logic rdy;
        rdy = expReady();
        @(posedge clk);
        if (rst_n) begin
            mReg[15] = pc + 32'd4;
            if (we) begin
                mReg[waddr] = wdata;
                if (mCnt[waddr] > 0) mCnt[waddr]--;
            end
            if (rsv_valid && rdy) mCnt[rsv_addr]++;
        end
        #1;
    endtask

    initial begin
        idleInputs();
        pc = '0;
        modelClear();

        // Reset state, with a reservation request presented during reset.
        #1 rst_n = 1'b0;
        rsv_valid = 1'b1;
        rsv_addr = 4'd9;
        #2;
        settle();
        checkVal("rstData", rd_data[DW-1:0], 32'h0);
        checkVal("rstReady", DW'(rsv_ready), 32'h1);
        checkVal("rstStall", DW'(stall), 32'h0);

        // PC shadow load after reset release.
        @(negedge clk);
        rst_n = 1'b1;
        idleInputs();
        pc = 32'h100;
        rd_addr = {4'd0, 4'd15};
        tick();
        settle();
        checkVal("pcShadow", rd_data[DW-1:0], 32'h104);
        checkVal("pcBusy", DW'(rd_busy), 32'h0);
        checkVal("pcStall", DW'(stall), 32'h0);

        // Write bypass and persistence.
        we = 1'b1; waddr = 4'd3; wdata = 32'hDEADBEEF; rd_addr = {4'd0, 4'd3};
        settle();
        checkVal("bypassR3", rd_data[DW-1:0], 32'hDEADBEEF);
        tick();
        we = 1'b0;
        settle();
        checkVal("storedR3", rd_data[DW-1:0], 32'hDEADBEEF);

        // Reserve r5, then hazard, then final producer bypassed.
        rsv_valid = 1'b1; rsv_addr = 4'd5;
        settle();
        tick();
        rsv_valid = 1'b0; rd_en = 2'b01; rd_addr = {4'd0, 4'd5};
        settle();
        checkVal("r5Busy", DW'(rd_busy[0]), 32'h1);
        checkVal("r5Stall", DW'(stall), 32'h1);
        we = 1'b1; waddr = 4'd5; wdata = 32'h55;
        settle();
        checkVal("r5BypBusy", DW'(rd_busy[0]), 32'h0);
        checkVal("r5BypData", rd_data[DW-1:0], 32'h55);
        checkVal("r5BypStall", DW'(stall), 32'h0);
        tick();
        idleInputs();

        // Saturate r7, then reserve while releasing.
        rsv_valid = 1'b1; rsv_addr = 4'd7;
        for (int k = 0; k < 3; k++) begin
            settle();
            checkVal($sformatf("r7Rsv%0d", k), DW'(rsv_ready), 32'h1);
            tick();
        end
        settle();
        checkVal("r7Full", DW'(rsv_ready), 32'h0);
        checkVal("r7FullStall", DW'(stall), 32'h1);
        we = 1'b1; waddr = 4'd7; wdata = 32'h77;
        settle();
        checkVal("r7FullRel", DW'(rsv_ready), 32'h1);
        checkVal("r7FullRelStall", DW'(stall), 32'h0);
        tick();
        we = 1'b0; rd_en = 2'b01; rd_addr = {4'd0, 4'd7};
        settle();
        checkVal("r7StillBusy", DW'(rd_busy[0]), 32'h1);
        checkVal("r7StillFull", DW'(rsv_ready), 32'h0);
        idleInputs();

        // Reserve and release r2 together with one pending.
        rsv_valid = 1'b1; rsv_addr = 4'd2;
        settle();
        tick();
        we = 1'b1; waddr = 4'd2; wdata = 32'h22;
        settle();
        tick();
        idleInputs();
        rd_addr = {4'd0, 4'd2};
        settle();
        checkVal("r2NetBusy", DW'(rd_busy[0]), 32'h1);
        checkVal("r2Data", rd_data[DW-1:0], 32'h22);

        // Asynchronous reset with reservations pending on r2 and r7.
        rd_addr = {4'd7, 4'd2};
        rst_n = 1'b0;
        #1;
        modelClear();
        checkVal("arstBusy", DW'(rd_busy), 32'h0);
        checkVal("arstData0", rd_data[DW-1:0], 32'h0);
        checkVal("arstData1", rd_data[2*DW-1:DW], 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rsv_valid = 1'b1; rsv_addr = 4'd7; rd_en = 2'b11;
        settle();
        checkVal("postRstReady", DW'(rsv_ready), 32'h1);
        checkVal("postRstBusy", DW'(rd_busy), 32'h0);
        tick();
        idleInputs();

        // Random traffic, reservations concentrated on a few registers.
        for (int n = 0; n < 500; n++) begin
            pc        = $urandom;
            we        = 1'($urandom_range(0, 1));
            waddr     = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            wdata     = $urandom;
            rd_en     = 2'($urandom_range(0, 3));
            rd_addr   = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 4))};
            rsv_valid = 1'($urandom_range(0, 1));
            rsv_addr  = 4'($urandom_range(0, 3));
            settle();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
